// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state enum, default halt word, reset PC and ROM select codes.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC       = 32'd0;

    localparam logic MODE_ROM1 = 1'b0;
    localparam logic MODE_ROM2 = 1'b1;

endpackage

// File: rtl/fetch_sequencer_down_counter.sv
// Loadable down counter with zero flag, used to time the post-halt drain.
// Ports: clk, rst (sync, active-high), load/load_val, dec, zero.
module seq_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: start/select program, stall, redirect, halt drain.
// Ports: clk, rst (sync, active-high), start, mode_req, stall_req,
//   redirect_valid/target, instr, pc_plus1 in; fetch_en, pc_next, flush
//   (combinational), mode_sel, busy, done, timeout, instr_count (registered).
// Optional watchdog: define FETCH_SEQ_WATCHDOG_EN to enable timeout.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                CNT_W        = 16,
    parameter int                DRAIN_CYCLES = 4,
    parameter logic [ADDR_W-1:0] HALT_INSTR   = HALT_INSTR_DEF,
    parameter int                WDOG_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_req,
    input  logic              stall_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic [ADDR_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc_plus1,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] pc_next,
    output logic              mode_sel,
    output logic              flush,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    seq_state_e state, state_n;

    logic accept;
    logic count_inc;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic wdog_hit;

    seq_down_counter #(
        .W(DCW)
    ) u_drain_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(DRAIN_LOAD),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        fetch_en  = 1'b0;
        pc_next   = PC_RST;
        flush     = 1'b0;
        accept    = 1'b0;
        count_inc = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    fetch_en = 1'b1;
                    state_n  = S_RUN;
                end
            end
            S_RUN: begin
                pc_next = pc_plus1;
                if (wdog_hit) begin
                    state_n = S_DONE;
                end else if (redirect_valid) begin
                    fetch_en = 1'b1;
                    pc_next  = redirect_target;
                    flush    = 1'b1;
                end else if (stall_req) begin
                    fetch_en = 1'b0;
                end else if (instr == HALT_INSTR) begin
                    // PC freezes on the halt word while older stages drain.
                    cnt_load = 1'b1;
                    state_n  = S_DRAIN;
                end else begin
                    fetch_en  = 1'b1;
                    count_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    // Halt was on the wrong path: resume at the target.
                    fetch_en = 1'b1;
                    pc_next  = redirect_target;
                    flush    = 1'b1;
                    state_n  = S_RUN;
                end else if (cnt_zero) begin
                    state_n = S_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sel    <= MODE_ROM1;
            instr_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept) begin
                mode_sel    <= mode_req;
                instr_count <= '0;
            end else if (count_inc && (instr_count != '1)) begin
                instr_count <= instr_count + 1'b1;
            end
            busy <= (state_n == S_RUN) || (state_n == S_DRAIN);
            done <= (state_n == S_DONE);
        end
    end

`ifdef FETCH_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt;

    // Fires on the WDOG_CYCLES-th RUN cycle since start.
    assign wdog_hit = (state == S_RUN) && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else if (accept) begin
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else if (state == S_RUN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_hit    = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule
